// File: rtl/recorder_pkg.sv
// rtl/recorder_pkg.sv - shared state encoding and constants for the trace sequencer
package recorder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLDOFF = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    localparam int TO_PRESCALE   = 1024;
    localparam int HOLDOFF_UNIT  = 8;
    localparam int HOLDOFF_MIN   = 2;
    localparam int STAT_TRIG_BIT = 4;
    localparam int STAT_TO_BIT   = 3;

endpackage

// File: rtl/trace_sequencer_if.sv
// rtl/trace_sequencer_if.sv - control/handshake bundle between sequencer and data recorder
interface trace_sequencer_if;

    logic [7:0] rec_ctl;
    logic       rec_stopped;
    logic       rd_done;

    modport master (output rec_ctl, input rec_stopped, input rd_done);
    modport slave  (input rec_ctl, output rec_stopped, output rd_done);

endinterface

// File: rtl/rec_tick_timer.sv
// rtl/rec_tick_timer.sv - prescaled down-counter; done is high in the last cycle of a units*prescale interval
module rec_tick_timer #(
    parameter int PRE_W = 11
) (
    input  logic             clk8M,
    input  logic             reset_n,
    input  logic             load,
    input  logic [7:0]       units,
    input  logic [PRE_W-1:0] prescale,
    output logic             done
);

    logic [7:0]       unit_cnt;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_rel;

    // Loaded as (units-1, prescale-1) so that done lands exactly in cycle units*prescale after the load edge.
    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            unit_cnt <= '0;
            pre_cnt  <= '0;
            pre_rel  <= '0;
        end else if (load) begin
            unit_cnt <= units - 8'd1;
            pre_cnt  <= prescale - PRE_W'(1);
            pre_rel  <= prescale - PRE_W'(1);
        end else if (pre_cnt == '0) begin
            pre_cnt  <= pre_rel;
            unit_cnt <= unit_cnt - 8'd1;
        end else begin
            pre_cnt  <= pre_cnt - PRE_W'(1);
        end
    end

    assign done = (unit_cnt == '0) && (pre_cnt == '0);

endmodule

// File: rtl/trace_sequencer.sv
// rtl/trace_sequencer.sv - arms the data recorder, catches the first masked detector pulse, hands off to readout
module trace_sequencer
    import recorder_pkg::*;
#(
    parameter int TS_W        = 16,
    parameter int TO_PRESCALE = recorder_pkg::TO_PRESCALE
) (
    input  logic             clk8M,
    input  logic             reset_n,
    input  logic             cfg_arm,
    input  logic             cfg_auto,
    input  logic [5:0]       cfg_mask,
    input  logic [7:0]       cfg_holdoff,
    input  logic [7:0]       cfg_timeout,
    input  logic [5:0]       det,
    trace_sequencer_if.master rec,
    output logic [7:0]       status,
    output logic [5:0]       trig_src,
    output logic [TS_W-1:0]  trig_time,
    output logic [7:0]       trig_cnt,
    output logic             irq
);

    localparam int PRE_W = ($clog2(TO_PRESCALE + 1) > 4) ? $clog2(TO_PRESCALE + 1) : 4;

    seq_state_e       state;
    logic             arm_low_q;
    logic             to_en;
    logic             trig_f;
    logic             to_f;
    logic [TS_W-1:0]  ts;
    logic [7:0]       rec_ctl_q;

    logic [5:0]       hit_src;
    logic             hit;
    logic             start_holdoff;
    logic             start_armed;
    logic             tmr_load;
    logic             tmr_done;
    logic [7:0]       tmr_units;
    logic [PRE_W-1:0] tmr_pre;

    assign hit_src = det & cfg_mask;
    assign hit     = |hit_src;

    // arm_low_q resets to 0, so an arm level already high at reset release is not taken as an edge.
    assign start_holdoff = cfg_arm && (((state == ST_IDLE) && arm_low_q) ||
                                       ((state == ST_DONE) && rec.rd_done && cfg_auto));
    assign start_armed   = cfg_arm && (state == ST_HOLDOFF) && tmr_done;
    assign tmr_load      = start_holdoff || start_armed;

    always_comb begin
        tmr_units = cfg_holdoff;
        tmr_pre   = PRE_W'(HOLDOFF_UNIT);
        if (state == ST_HOLDOFF) begin
            tmr_units = cfg_timeout;
            tmr_pre   = PRE_W'(TO_PRESCALE);
        end else if (cfg_holdoff == 8'd0) begin
            tmr_units = 8'd1;
            tmr_pre   = PRE_W'(HOLDOFF_MIN);
        end
    end

    rec_tick_timer #(.PRE_W(PRE_W)) u_timer (
        .clk8M    (clk8M),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .units    (tmr_units),
        .prescale (tmr_pre),
        .done     (tmr_done)
    );

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + 1'b1;
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            arm_low_q <= 1'b0;
            to_en     <= 1'b0;
            trig_f    <= 1'b0;
            to_f      <= 1'b0;
            rec_ctl_q <= '0;
            trig_src  <= '0;
            trig_time <= '0;
            trig_cnt  <= '0;
            irq       <= 1'b0;
        end else begin
            arm_low_q <= ~cfg_arm;
            irq       <= 1'b0;
            if (!cfg_arm) begin
                state     <= ST_IDLE;
                rec_ctl_q <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start_holdoff) begin
                        state    <= ST_HOLDOFF;
                        trig_cnt <= '0;
                        trig_f   <= 1'b0;
                        to_f     <= 1'b0;
                        trig_src <= '0;
                    end
                    ST_HOLDOFF: begin
                        rec_ctl_q <= '0;
                        if (start_armed) begin
                            state     <= ST_ARMED;
                            rec_ctl_q <= {2'b10, cfg_mask};
                            to_en     <= (cfg_timeout != 8'd0);
                        end
                    end
                    // Trigger is checked before the timeout so a coincident pulse wins.
                    ST_ARMED: if (hit) begin
                        state     <= ST_CAPTURE;
                        trig_src  <= hit_src;
                        trig_time <= ts;
                        if (trig_cnt != 8'hFF) trig_cnt <= trig_cnt + 8'd1;
                    end else if (to_en && tmr_done) begin
                        state     <= ST_IDLE;
                        to_f      <= 1'b1;
                        irq       <= 1'b1;
                        rec_ctl_q <= '0;
                    end else begin
                        rec_ctl_q <= {2'b10, cfg_mask};
                    end
                    ST_CAPTURE: if (rec.rec_stopped) begin
                        state  <= ST_DONE;
                        trig_f <= 1'b1;
                        irq    <= 1'b1;
                    end
                    ST_DONE: if (rec.rd_done) begin
                        state     <= start_holdoff ? ST_HOLDOFF : ST_IDLE;
                        rec_ctl_q <= '0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        rec_ctl_q <= '0;
                    end
                endcase
            end
        end
    end

    assign rec.rec_ctl = rec_ctl_q;

    always_comb begin
        status                = '0;
        status[2:0]           = state;
        status[STAT_TRIG_BIT] = trig_f;
        status[STAT_TO_BIT]   = to_f;
    end

endmodule
